// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-ported data memory between the datapath and host ports (optional perf counters via ARB_PERF_CNT_EN)
module data_mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_LOCK     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dp_req,
  input  logic                  dp_we,
  input  logic [ADDR_WIDTH-1:0] dp_addr,
  input  logic [DATA_WIDTH-1:0] dp_wdata,
  output logic                  dp_gnt,
  output logic                  dp_rvalid,
  output logic [DATA_WIDTH-1:0] dp_rdata,
  output logic                  dp_lock,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic                  host_lock,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [15:0]           perf_dp_stall,
  output logic [15:0]           perf_host_gnt
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DP    = 2'd1;
  localparam logic [1:0] S_HOST  = 2'd2;
  localparam logic [1:0] S_HLOCK = 2'd3;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = $clog2(MAX_LOCK + 1);

  logic [1:0]            state_q, state_d;
  logic [SW-1:0]         starve_cnt_q, starve_cnt_d;
  logic [LW-1:0]         lock_cnt_q, lock_cnt_d;
  logic                  dp_rvalid_q, dp_rvalid_d, host_rvalid_q, host_rvalid_d;
  logic [DATA_WIDTH-1:0] dp_rdata_q, dp_rdata_d, host_rdata_q, host_rdata_d;
  logic                  host_win, dp_win, starved, lock_end;

  // Arbitration: held lock or starvation lets host pre-empt the datapath, otherwise datapath first
  always_comb begin
    starved   = starve_cnt_q == SW'(STARVE_LIMIT);
    lock_end  = (state_q == S_HLOCK) && (lock_cnt_q == LW'(MAX_LOCK - 1));
    host_win  = host_req & ((state_q == S_HLOCK) | starved | ~dp_req);
    dp_win    = dp_req & ~host_win;
    dp_gnt    = dp_win;
    host_gnt  = host_win;
    dp_lock   = ~(dp_req & ~dp_win);
    mem_en    = dp_win | host_win;
    mem_we    = host_win ? host_we : (dp_win & dp_we);
    mem_addr  = host_win ? host_addr : dp_addr;
    mem_wdata = host_win ? host_wdata : dp_wdata;
  end

  // Next owner state, fairness/lock counters, and read-return tracking
  always_comb begin
    state_d       = host_win ? (lock_end ? S_IDLE : (host_lock ? S_HLOCK : S_HOST)) : (dp_win ? S_DP : S_IDLE);
    lock_cnt_d    = (host_win & host_lock & ~lock_end) ? ((state_q == S_HLOCK) ? lock_cnt_q + LW'(1) : LW'(1)) : '0;
    starve_cnt_d  = (host_req & ~host_win) ? (starved ? starve_cnt_q : starve_cnt_q + SW'(1)) : '0;
    dp_rvalid_d   = dp_win & ~dp_we;
    host_rvalid_d = host_win & ~host_we;
    dp_rdata_d    = dp_rvalid_q ? mem_rdata : dp_rdata_q;
    host_rdata_d  = host_rvalid_q ? mem_rdata : host_rdata_q;
    dp_rvalid     = dp_rvalid_q;
    host_rvalid   = host_rvalid_q;
    dp_rdata      = dp_rdata_d;
    host_rdata    = host_rdata_d;
  end

  // Arbiter state registers; read data is held after its return so it stays stable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      starve_cnt_q  <= '0;
      lock_cnt_q    <= '0;
      dp_rvalid_q   <= 1'b0;
      host_rvalid_q <= 1'b0;
      dp_rdata_q    <= '0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      lock_cnt_q    <= lock_cnt_d;
      dp_rvalid_q   <= dp_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      dp_rdata_q    <= dp_rdata_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_dp_stall_q, perf_dp_stall_d, perf_host_gnt_q, perf_host_gnt_d;

  // Wrapping counters of datapath stall cycles and host grants
  always_comb begin
    perf_dp_stall_d = perf_dp_stall_q + 16'(dp_req & ~dp_win);
    perf_host_gnt_d = perf_host_gnt_q + 16'(host_win);
    perf_dp_stall   = perf_dp_stall_q;
    perf_host_gnt   = perf_host_gnt_q;
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_dp_stall_q <= '0;
      perf_host_gnt_q <= '0;
    end else begin
      perf_dp_stall_q <= perf_dp_stall_d;
      perf_host_gnt_q <= perf_host_gnt_d;
    end
  end
`else
  assign perf_dp_stall = '0;
  assign perf_host_gnt = '0;
`endif
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed scenarios checked against a cycle model of the arbitration rules
module tb_data_mem_arbiter;
  localparam int STARVE = 4;
  localparam int LOCKMAX = 8;

  logic clk = 0;
  logic rst_n = 0;
  logic dp_req = 0, dp_we = 0, host_req = 0, host_we = 0, host_lock = 0;
  logic [15:0] dp_addr = 0, dp_wdata = 0, host_addr = 0, host_wdata = 0;
  logic dp_gnt, dp_rvalid, dp_lock, host_gnt, host_rvalid, mem_en, mem_we;
  logic [15:0] dp_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata, perf_dp_stall, perf_host_gnt;

  int checks = 0;
  int errors = 0;

  data_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .dp_req(dp_req), .dp_we(dp_we), .dp_addr(dp_addr), .dp_wdata(dp_wdata),
    .dp_gnt(dp_gnt), .dp_rvalid(dp_rvalid), .dp_rdata(dp_rdata), .dp_lock(dp_lock),
    .host_req(host_req), .host_we(host_we), .host_lock(host_lock), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .perf_dp_stall(perf_dp_stall), .perf_host_gnt(perf_host_gnt)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:255];
  logic [15:0] mmem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'(i * 3);
      mmem[i] = 16'(i * 3);
    end
    mem[16] = 16'h1234;
    mmem[16] = 16'h1234;
    mem_rdata = 0;
  end

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else mem_rdata <= mem[mem_addr[7:0]];
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  int m_starve = 0, m_held = 0, m_stall = 0, m_hg = 0;
  bit m_dpv = 0, m_hv = 0;
  logic [15:0] m_dpd = 0, m_hd = 0;

  always @(negedge clk) begin
    bit hw, dw;
    hw = host_req && (m_held > 0 || m_starve >= STARVE || !dp_req);
    dw = dp_req && !hw;
    chk("dp_gnt", dp_gnt, dw);
    chk("host_gnt", host_gnt, hw);
    chk("mem_en", mem_en, hw || dw);
    chk("dp_lock", dp_lock, !(dp_req && !dw));
    if (hw || dw) begin
      chk("mem_we", mem_we, hw ? host_we : dp_we);
      chk("mem_addr", mem_addr, hw ? host_addr : dp_addr);
      if (mem_we) chk("mem_wdata", mem_wdata, hw ? host_wdata : dp_wdata);
    end
    chk("dp_rvalid", dp_rvalid, m_dpv);
    chk("dp_rdata", dp_rdata, m_dpd);
    chk("host_rvalid", host_rvalid, m_hv);
    chk("host_rdata", host_rdata, m_hd);
`ifdef ARB_PERF_CNT_EN
    chk("perf_dp_stall", perf_dp_stall, 16'(m_stall));
    chk("perf_host_gnt", perf_host_gnt, 16'(m_hg));
`else
    chk("perf_dp_stall", perf_dp_stall, 0);
    chk("perf_host_gnt", perf_host_gnt, 0);
`endif
    if (!rst_n) begin
      m_starve = 0; m_held = 0; m_stall = 0; m_hg = 0;
      m_dpv = 0; m_hv = 0; m_dpd = 0; m_hd = 0;
    end else begin
      m_dpv = dw && !dp_we;
      m_hv = hw && !host_we;
      if (m_dpv) m_dpd = mmem[dp_addr[7:0]];
      if (m_hv) m_hd = mmem[host_addr[7:0]];
      m_starve = (host_req && !hw) ? ((m_starve + 1 > STARVE) ? STARVE : m_starve + 1) : 0;
      m_held = (hw && host_lock) ? ((m_held + 1 == LOCKMAX) ? 0 : m_held + 1) : 0;
      m_stall = (m_stall + (dp_req && !dw)) % 65536;
      m_hg = (m_hg + hw) % 65536;
    end
    if (hw && host_we) mmem[host_addr[7:0]] = host_wdata;
    else if (dw && dp_we) mmem[dp_addr[7:0]] = dp_wdata;
  end

  task automatic drive(input bit dr, input bit dwe, input logic [15:0] da, input logic [15:0] dd,
                       input bit hr, input bit hwe, input bit hl, input logic [15:0] ha, input logic [15:0] hd);
    dp_req = dr; dp_we = dwe; dp_addr = da; dp_wdata = dd;
    host_req = hr; host_we = hwe; host_lock = hl; host_addr = ha; host_wdata = hd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(negedge clk);
    chk("reset dp_rvalid", dp_rvalid, 0);
    chk("reset host_rvalid", host_rvalid, 0);
    chk("reset dp_rdata", dp_rdata, 0);
    next_cycle();
    rst_n = 1;
    drive(1, 0, 16'h0010, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t1 dp_gnt", dp_gnt, 1);
    chk("t1 dp_lock", dp_lock, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t1 dp_rvalid", dp_rvalid, 1);
    chk("t1 dp_rdata", dp_rdata, 16'h1234);
    chk("t1 dp_lock idle", dp_lock, 1);
    next_cycle();
    rst_n = 0;
    next_cycle();
    rst_n = 1;
    drive(1, 0, 16'h0010, 0, 1, 0, 0, 16'h0030, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 4) begin
        chk("t2 host_gnt c4", host_gnt, 1);
        chk("t2 dp_lock c4", dp_lock, 0);
      end else if (i < 9) begin
        chk("t2 dp_gnt", dp_gnt, 1);
        chk("t2 dp_lock", dp_lock, 1);
      end
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef ARB_PERF_CNT_EN
    chk("t6 perf_dp_stall", perf_dp_stall, 4);
    chk("t6 perf_host_gnt", perf_host_gnt, 4);
`else
    chk("t6 perf_dp_stall off", perf_dp_stall, 0);
    chk("t6 perf_host_gnt off", perf_host_gnt, 0);
`endif
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      drive(i > 0, 0, 16'h0020, 0, 1, 1, 1, 16'h0020, 16'hBEEF);
      @(negedge clk);
      if (i < 8) chk("t3 host_gnt held", host_gnt, 1);
      if (i == 8) chk("t3 dp_gnt c8", dp_gnt, 1);
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 1, 1, 0, 16'h0005, 16'h00AA);
    next_cycle();
    drive(1, 0, 16'h0005, 0, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t4 dp_rvalid", dp_rvalid, 1);
    chk("t4 dp_rdata", dp_rdata, 16'h00AA);
    next_cycle();
    drive(0, 0, 0, 0, 1, 0, 0, 16'h0010, 0);
    rst_n = 0;
    @(negedge clk);
    chk("t5 host_gnt", host_gnt, 1);
    next_cycle();
    rst_n = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t5 host_rvalid dropped", host_rvalid, 0);
    chk("t5 perf_host_gnt", perf_host_gnt, 0);
    chk("t5 host_rdata", host_rdata, 0);
    next_cycle();
    drive(1, 1, 16'h0007, 16'h5A5A, 1, 0, 0, 16'h0007, 0);
    @(negedge clk);
    chk("t5 idle after reset dp first", dp_gnt, 1);
    next_cycle();
    drive(0, 0, 0, 0, 1, 0, 1, 16'h0007, 0);
    next_cycle();
    drive(1, 0, 16'h0001, 0, 1, 0, 0, 16'h0002, 0);
    next_cycle();
    drive(1, 0, 16'h0003, 0, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
